// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM pipeline stage: access-size encodings, FSM states
// and the default wait-state count.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE  = 2'b00,
    SIZE_HALF  = 2'b01,
    SIZE_WORD  = 2'b10,
    SIZE_DWORD = 2'b11
  } size_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int WAIT_STATES_DEFAULT = 0;

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM bundle in, MEM/WB bundle out, plus stall and branch-taken back to fetch.
interface mem_stage_if #(
  parameter int DATA_W = 32
) ();

  logic              in_valid;
  logic [DATA_W-1:0] ALUResult;
  logic [DATA_W-1:0] WriteData;
  logic [4:0]        WriteReg;
  logic [1:0]        WBControl;
  logic              MemWrite;
  logic              MemRead;
  logic              Branch;
  logic              Zero;
  logic              Unsigned;
  logic [1:0]        Size;

  logic              stall;
  logic              out_valid;
  logic [DATA_W-1:0] ReadData;
  logic [DATA_W-1:0] ALUResult_out;
  logic [4:0]        WriteReg_out;
  logic [1:0]        WBControl_out;
  logic              misalign;
  logic              PCSrc;

  modport master (
    output in_valid, ALUResult, WriteData, WriteReg, WBControl,
           MemWrite, MemRead, Branch, Zero, Unsigned, Size,
    input  stall, out_valid, ReadData, ALUResult_out, WriteReg_out,
           WBControl_out, misalign, PCSrc
  );

  modport slave (
    input  in_valid, ALUResult, WriteData, WriteReg, WBControl,
           MemWrite, MemRead, Branch, Zero, Unsigned, Size,
    output stall, out_valid, ReadData, ALUResult_out, WriteReg_out,
           WBControl_out, misalign, PCSrc
  );

endinterface

// File: rtl/dmem_bank.sv
// Data RAM with per-byte write enables: writes land on the rising edge,
// reads are combinational from the addressed word.
module dmem_bank #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 256,
  localparam int LANES  = DATA_W / 8,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [LANES-1:0]  be,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array is deliberately left out of reset; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < LANES; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: wait-state FSM, alignment check, byte-lane steering,
// load extension and the MEM/WB output register around a dmem_bank.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = WAIT_STATES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_stage_if.slave  bus
);

  localparam int LANES = DATA_W / 8;
  localparam int OFF_W = $clog2(LANES);
  localparam int AW    = $clog2(DEPTH);
  localparam int BW    = $clog2(DATA_W);

  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [4:0]        wreg;
    logic [1:0]        wbc;
    logic              mem_write;
    logic              mem_read;
    logic              unsigned_ld;
    size_e             size;
  } req_t;

  req_t              in_req, req_q, cur;
  state_e            state;
  logic [2:0]        cnt;
  logic [OFF_W-1:0]  off;
  logic [AW-1:0]     idx;
  logic              is_mem, misal, fault, do_write, do_read, complete;
  logic [LANES-1:0]  lane_mask, be;
  logic [DATA_W-1:0] val_mask, wdata_lanes, rdata, rd_shift, ext;
  logic [BW-1:0]     sign_idx;

  logic              ov_q, mis_q;
  logic [DATA_W-1:0] rd_q, alu_q;
  logic [4:0]        wr_q;
  logic [1:0]        wb_q;

  always_comb begin
    in_req.addr        = bus.ALUResult;
    in_req.wdata       = bus.WriteData;
    in_req.wreg        = bus.WriteReg;
    in_req.wbc         = bus.WBControl;
    in_req.mem_write   = bus.MemWrite;
    in_req.mem_read    = bus.MemRead;
    in_req.unsigned_ld = bus.Unsigned;
    in_req.size        = size_e'(bus.Size);
  end

  // A waited access works from the bundle captured at acceptance.
  assign cur = (state == BUSY) ? req_q : in_req;
  assign off = cur.addr[OFF_W-1:0];
  assign idx = cur.addr[OFF_W+AW-1:OFF_W];

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    misal     = 1'b0;
    lane_mask = '0;
    val_mask  = '0;
    sign_idx  = '0;
    case (cur.size)
      SIZE_BYTE: begin
        lane_mask = LANES'(4'h1);
        val_mask  = DATA_W'(8'hFF);
        sign_idx  = BW'(7);
      end
      SIZE_HALF: begin
        misal     = off[0];
        lane_mask = LANES'(4'h3);
        val_mask  = DATA_W'(16'hFFFF);
        sign_idx  = BW'(15);
      end
      SIZE_WORD: begin
        misal     = |off[1:0];
        lane_mask = LANES'(4'hF);
        val_mask  = DATA_W'(32'hFFFF_FFFF);
        sign_idx  = BW'(31);
      end
      default: begin
        misal     = (DATA_W == 64) ? (|off) : 1'b1;
        lane_mask = '1;
        val_mask  = '1;
        sign_idx  = BW'(DATA_W - 1);
      end
    endcase
  end

  assign is_mem   = cur.mem_read | cur.mem_write;
  assign fault    = is_mem & misal;
  assign do_write = is_mem & ~misal & cur.mem_write;
  assign do_read  = is_mem & ~misal & cur.mem_read & ~cur.mem_write;

  // Completion: a zero-wait bundle in IDLE, or the last cycle of BUSY.
  assign complete = (state == IDLE) ? (bus.in_valid && !(is_mem && WAIT_STATES > 0))
                                    : (cnt == 3'd1);

  assign be          = lane_mask << off;
  assign wdata_lanes = cur.wdata << {off, 3'b000};

  dmem_bank #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_bank (
    .clk   (clk),
    .we    (complete & do_write & rst_n),
    .be    (be),
    .addr  (idx),
    .wdata (wdata_lanes),
    .rdata (rdata)
  );

  assign rd_shift = rdata >> {off, 3'b000};
  assign ext      = (rd_shift & val_mask) |
                    ((!cur.unsigned_ld && rd_shift[sign_idx]) ? ~val_mask : '0);

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      req_q <= '0;
      ov_q  <= 1'b0;
      mis_q <= 1'b0;
      rd_q  <= '0;
      alu_q <= '0;
      wr_q  <= '0;
      wb_q  <= '0;
    end else begin
      ov_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid && is_mem && WAIT_STATES > 0) begin
            req_q <= in_req;
            cnt   <= 3'(WAIT_STATES);
            state <= BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) state <= IDLE;
        end
      endcase
      if (complete) begin
        ov_q  <= 1'b1;
        mis_q <= fault;
        rd_q  <= do_read ? ext : '0;
        alu_q <= cur.addr;
        wr_q  <= cur.wreg;
        wb_q  <= fault ? 2'b00 : cur.wbc;
      end
    end
  end

  assign bus.stall         = (state == BUSY);
  assign bus.out_valid     = ov_q;
  assign bus.misalign      = mis_q;
  assign bus.ReadData      = rd_q;
  assign bus.ALUResult_out = alu_q;
  assign bus.WriteReg_out  = wr_q;
  assign bus.WBControl_out = wb_q;
  assign bus.PCSrc         = bus.in_valid & bus.Branch & bus.Zero;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench: two mem_stage instances (0 and 3 wait states) share one
// stimulus driver; a byte-array memory model predicts every MEM/WB bundle.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int MEM_BYTES = 256 * 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int          sel      = 0;
  logic        in_valid = 1'b0;
  logic [31:0] alu = '0, wdata = '0;
  logic [4:0]  wreg = '0;
  logic [1:0]  wbc = '0, size = '0;
  logic        mw = 1'b0, mr = 1'b0, br = 1'b0, zr = 1'b0, uns = 1'b0;

  mem_stage_if #(.DATA_W(32)) bus0 ();
  mem_stage_if #(.DATA_W(32)) bus3 ();

  assign bus0.in_valid  = in_valid && (sel == 0);
  assign bus3.in_valid  = in_valid && (sel == 1);
  assign bus0.ALUResult = alu;   assign bus3.ALUResult = alu;
  assign bus0.WriteData = wdata; assign bus3.WriteData = wdata;
  assign bus0.WriteReg  = wreg;  assign bus3.WriteReg  = wreg;
  assign bus0.WBControl = wbc;   assign bus3.WBControl = wbc;
  assign bus0.MemWrite  = mw;    assign bus3.MemWrite  = mw;
  assign bus0.MemRead   = mr;    assign bus3.MemRead   = mr;
  assign bus0.Branch    = br;    assign bus3.Branch    = br;
  assign bus0.Zero      = zr;    assign bus3.Zero      = zr;
  assign bus0.Unsigned  = uns;   assign bus3.Unsigned  = uns;
  assign bus0.Size      = size;  assign bus3.Size      = size;

  mem_stage #(.DATA_W(32), .DEPTH(256), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  mem_stage #(.DATA_W(32), .DEPTH(256), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3));

  typedef struct {
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  wreg;
    logic [1:0]  wbc;
    logic        mis;
    int          cyc;
  } exp_t;

  exp_t       q0[$];
  exp_t       q1[$];
  logic [7:0] mm [2][MEM_BYTES];
  int         checks = 0;
  int         fails  = 0;
  int         cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual 0x%08h, required 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: byte-addressed little-endian memory, plain arithmetic for extension.
  task automatic predict(input int s, output exp_t e);
    int     n, ba;
    bit     is_mem, mis;
    longint v;
    n      = 1 << size;
    is_mem = mr || mw;
    mis    = is_mem && (size == 2'b11 || (alu % n) != 0);
    ba     = int'(alu % MEM_BYTES);
    e.alu  = alu;
    e.wreg = wreg;
    e.wbc  = mis ? 2'b00 : wbc;
    e.mis  = mis;
    e.rd   = '0;
    e.cyc  = cyc + 1 + ((is_mem && s == 1) ? 3 : 0);
    if (is_mem && !mis) begin
      if (mw) begin
        for (int i = 0; i < n; i++) mm[s][ba+i] = wdata[8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < n; i++) v += longint'(mm[s][ba+i]) << (8 * i);
        if (!uns && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        e.rd = v[31:0];
      end
    end
  endtask

  task automatic mon(input int w, input logic [31:0] rd, a, input logic [4:0] wr,
                     input logic [1:0] wb, input logic mis);
    exp_t e;
    if ((w == 0 && q0.size() == 0) || (w == 1 && q1.size() == 0)) begin
      check(w == 0 ? "dut0_unexpected_out_valid" : "dut3_unexpected_out_valid", 32'd1, 32'd0);
      return;
    end
    if (w == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    check("read_data",     rd,        e.rd);
    check("alu_result",    a,         e.alu);
    check("write_reg",     32'(wr),   32'(e.wreg));
    check("wb_control",    32'(wb),   32'(e.wbc));
    check("misalign",      32'(mis),  32'(e.mis));
    check("latency_cycle", 32'(cyc),  32'(e.cyc));
  endtask

  always @(negedge clk)
    if (rst_n === 1'b1 && bus0.out_valid === 1'b1)
      mon(0, bus0.ReadData, bus0.ALUResult_out, bus0.WriteReg_out, bus0.WBControl_out, bus0.misalign);

  always @(negedge clk)
    if (rst_n === 1'b1 && bus3.out_valid === 1'b1)
      mon(1, bus3.ReadData, bus3.ALUResult_out, bus3.WriteReg_out, bus3.WBControl_out, bus3.misalign);

  task automatic issue(input int s, input logic [31:0] a, d, input logic [4:0] r,
                       input logic [1:0] wb, input logic w_en, r_en, b, z, u,
                       input logic [1:0] sz, input bit track);
    exp_t e;
    int   guard = 0;
    @(negedge clk);
    in_valid = 1'b0;
    sel      = s;
    while (((s == 1) ? bus3.stall : bus0.stall) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) check("stall_timeout", 32'd1, 32'd0);
    alu = a; wdata = d; wreg = r; wbc = wb;
    mw = w_en; mr = r_en; br = b; zr = z; uns = u; size = sz;
    in_valid = 1'b1;
    #1 check("pcsrc", 32'((s == 1) ? bus3.PCSrc : bus0.PCSrc), 32'(b & z));
    if (track) begin
      predict(s, e);
      if (s == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    br = 1'b0;
    zr = 1'b0;
  endtask

  task automatic reset_outputs(input string tag, input logic ov, st, mis,
                               input logic [31:0] rd, a, input logic [4:0] wr,
                               input logic [1:0] wb);
    check({tag, "_rst_out_valid"}, 32'(ov),  32'd0);
    check({tag, "_rst_stall"},     32'(st),  32'd0);
    check({tag, "_rst_misalign"},  32'(mis), 32'd0);
    check({tag, "_rst_read_data"}, rd,       32'd0);
    check({tag, "_rst_alu_out"},   a,        32'd0);
    check({tag, "_rst_write_reg"}, 32'(wr),  32'd0);
    check({tag, "_rst_wb_ctrl"},   32'(wb),  32'd0);
  endtask

  initial begin
    int guard;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_outputs("dut0", bus0.out_valid, bus0.stall, bus0.misalign, bus0.ReadData,
                  bus0.ALUResult_out, bus0.WriteReg_out, bus0.WBControl_out);
    reset_outputs("dut3", bus3.out_valid, bus3.stall, bus3.misalign, bus3.ReadData,
                  bus3.ALUResult_out, bus3.WriteReg_out, bus3.WBControl_out);
    rst_n = 1'b1;

    // Give the tested address window defined contents in both RAMs.
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 16; i++)
        issue(s, 32'(i * 4), $urandom, 5'(i), 2'b01, 1, 0, 0, 0, 0, 2'b10, 1);

    // Zero-wait directed sequence, back to back.
    issue(0, 32'h4,   32'h1234_5678, 5'd1, 2'b01, 1, 0, 0, 0, 0, 2'b10, 1);
    issue(0, 32'h4,   32'h0,         5'd2, 2'b11, 0, 1, 0, 0, 0, 2'b10, 1);
    issue(0, 32'h5,   32'h80,        5'd3, 2'b01, 1, 0, 0, 0, 0, 2'b00, 1);
    issue(0, 32'h5,   32'h0,         5'd4, 2'b11, 0, 1, 0, 0, 0, 2'b00, 1);
    issue(0, 32'h5,   32'h0,         5'd5, 2'b11, 0, 1, 0, 0, 1, 2'b00, 1);
    issue(0, 32'h4,   32'h0,         5'd6, 2'b11, 0, 1, 0, 0, 0, 2'b10, 1);
    issue(0, 32'h404, 32'h0,         5'd7, 2'b11, 0, 1, 0, 0, 0, 2'b10, 1);
    issue(0, 32'h3,   32'h0,         5'd8, 2'b11, 0, 1, 0, 0, 0, 2'b01, 1);
    issue(0, 32'h3,   32'hBEEF,      5'd9, 2'b11, 1, 0, 0, 0, 0, 2'b01, 1);
    issue(0, 32'h0,   32'h0,         5'd10, 2'b11, 0, 1, 0, 0, 0, 2'b10, 1);
    issue(0, 32'h8,   32'hA5A5_0F0F, 5'd11, 2'b11, 1, 1, 0, 0, 0, 2'b10, 1);
    issue(0, 32'h8,   32'h0,         5'd12, 2'b11, 0, 1, 0, 0, 0, 2'b10, 1);
    issue(0, 32'h4,   32'h0,         5'd13, 2'b11, 0, 1, 0, 0, 0, 2'b11, 1);
    issue(0, 32'hCAFE_0000, 32'h0,   5'd14, 2'b10, 0, 0, 1, 1, 0, 2'b10, 1);
    issue(0, 32'h0000_0BAD, 32'h0,   5'd15, 2'b01, 0, 0, 1, 0, 0, 2'b10, 1);
    repeat (3) idle();

    // Three wait states: stall profile, PCSrc while stalled.
    issue(1, 32'h4, 32'h0, 5'd16, 2'b01, 0, 1, 0, 0, 0, 2'b10, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("stall_busy_1", 32'(bus3.stall), 32'd1);
    br = 1'b1; zr = 1'b1; in_valid = 1'b1;
    #1 check("pcsrc_during_stall", 32'(bus3.PCSrc), 32'd1);
    zr = 1'b0;
    #1 check("pcsrc_zero_clear", 32'(bus3.PCSrc), 32'd0);
    in_valid = 1'b0; br = 1'b0;
    @(negedge clk) check("stall_busy_2", 32'(bus3.stall), 32'd1);
    @(negedge clk) check("stall_busy_3", 32'(bus3.stall), 32'd1);
    @(negedge clk) check("stall_released", 32'(bus3.stall), 32'd0);

    // Reset in the second BUSY cycle of a store must leave memory untouched.
    issue(1, 32'h8, 32'hDEAD_BEEF, 5'd17, 2'b01, 1, 0, 0, 0, 0, 2'b10, 0);
    idle();
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    check("stall_after_abort", 32'(bus3.stall), 32'd0);
    issue(1, 32'h8, 32'h0, 5'd18, 2'b01, 0, 1, 0, 0, 0, 2'b10, 1);

    // Randomised traffic interleaved across both instances.
    for (int k = 0; k < 160; k++) begin
      int op;
      op = $urandom_range(0, 3);
      issue($urandom_range(0, 1), $urandom & 32'hFFFF_FC3F, $urandom, 5'($urandom),
            2'($urandom), op[1], op[0], 1'($urandom), 1'($urandom), 1'($urandom),
            2'($urandom_range(0, 3)), 1);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();

    guard = 0;
    while ((q0.size() != 0 || q1.size() != 0) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("drain_queues", 32'(q0.size() + q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter DATA_W, 32, data/address width in bits (32 or 64).
REQ-002 Parameter DEPTH, 256, data memory depth in DATA_W-bit words (power of two).
REQ-003 Parameter WAIT_STATES, 0, extra cycles per load/store (0..7).
REQ-004 Port clk  in  1  single clock; all state on rising edge.
REQ-005 Port rst_n  in  1  reset, synchronous, active-low.
REQ-006 Port in_valid  in  1  EX/MEM bundle valid.
REQ-007 Port ALUResult  in  DATA_W  byte address or pass-through result.
REQ-008 Port WriteData  in  DATA_W  store data, right-aligned.
REQ-009 Port WriteReg  in  5  destination register.
REQ-010 Port WBControl  in  2  writeback control, forwarded.
REQ-011 Port MemWrite, MemRead, Branch, Zero, Unsigned  in  1 each  stage controls; Unsigned selects zero-extended load.
REQ-012 Port Size  in  2  access size: 00 byte, 01 half, 10 word, 11 dword (DATA_W=64 only).
REQ-013 Port stall  out  1  upstream holds bundle while high.
REQ-014 Port out_valid  out  1  MEM/WB bundle valid.
REQ-015 Port ReadData, ALUResult_out  out  DATA_W  registered load result, registered ALU result.
REQ-016 Port WriteReg_out  out  5; WBControl_out  out  2  registered forwards.
REQ-017 Port misalign  out  1  registered fault flag aligned with out_valid.
REQ-018 Port PCSrc  out  1  branch taken.

Function
REQ-019 PCSrc SHALL equal in_valid & Branch & Zero, combinational, independent of stall.
REQ-020 FSM states IDLE, BUSY; IDLE accepts when in_valid; memory op with WAIT_STATES>0 enters BUSY with counter=WAIT_STATES, else stays IDLE.
REQ-021 BUSY SHALL decrement counter each cycle, hold stall=1, and return to IDLE when counter reaches 0, completing access that cycle.
REQ-022 stall SHALL be 0 in IDLE, 1 in BUSY; inputs during stall ignored.
REQ-023 Latency: out_valid SHALL assert WAIT_STATES+1 cycles after acceptance for memory ops, 1 cycle for non-memory ops, for exactly one cycle per bundle.
REQ-024 Word index SHALL be ALUResult[log2(DEPTH)+log2(DATA_W/8)-1 : log2(DATA_W/8)]; higher bits ignored (wrap modulo DEPTH).
REQ-025 Stores SHALL write only the byte lanes selected by Size and low address bits, little-endian; writes commit only on the completion cycle.
REQ-026 Loads SHALL extract the selected lanes and sign-extend, or zero-extend when Unsigned=1.
REQ-027 Misalignment (address not multiple of size, or Size=11 with DATA_W=32) SHALL suppress the access, set misalign=1, ReadData=0, WBControl_out=00.
REQ-028 MemRead and MemWrite both high SHALL perform the store only; ReadData=0.
REQ-029 Non-memory bundles SHALL forward ALUResult, WriteReg, WBControl with ReadData=0.
REQ-030 Back-to-back accepted bundles SHALL sustain one per cycle when WAIT_STATES=0.

Reset
REQ-031 rst_n=0 on a clock edge SHALL force IDLE, counter=0, stall=0, out_valid=0, misalign=0, all registered outputs 0.
REQ-032 Reset during BUSY SHALL abort the access; no memory write occurs.
REQ-033 Memory array contents SHALL not be reset.

Structure
REQ-034 Package mem_stage_pkg SHALL hold Size encodings, FSM state enum and WAIT_STATES default.
REQ-035 Sub-module dmem_bank SHALL implement the byte-lane-enabled synchronous RAM; mem_stage holds FSM, alignment, extension, MEM/WB register.

Verification
REQ-036 WAIT_STATES=0: store word 0x12345678 at 0x4, then load word 0x4 -> ReadData=0x12345678, out_valid one cycle after each acceptance.
REQ-037 Store byte 0x80 at 0x5, signed byte load 0x5 -> 0xFFFFFF80; Unsigned=1 -> 0x00000080; word 0x4 -> 0x12348078.
REQ-038 WAIT_STATES=3: load -> stall high 3 cycles, out_valid 4 cycles after acceptance; reset asserted in 2nd BUSY cycle of a store -> memory word unchanged.
REQ-039 Half load at 0x3 -> misalign=1, WBControl_out=00, ReadData=0, memory unchanged.
REQ-040 Branch=1, Zero=1, in_valid=1 -> PCSrc=1 same cycle, including while stall=1; Zero=0 -> PCSrc=0.
REQ-041 Address 0x404 with DEPTH=256, DATA_W=32 -> aliases word 1 (address 0x4).
